// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save datapath: resolver FSM states and
// the default operand geometry used by both the adder and the resolver.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

    localparam int CSA_WIDTH = 5;
    localparam int CSA_DIGIT = 1;

    // Counter width able to hold 0..n.
    function automatic int csa_cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/csa_resolver_if.sv
// Operand/result bus of the carry-save resolver.
interface csa_resolver_if #(
    parameter int WIDTH = csa_pkg::CSA_WIDTH
);
    // A transfer happens on a rising edge where valid && ready. The source
    // keeps valid and its payload stable until then; ready may change freely.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             busy;

    modport master (
        output in_valid, sum_in, carry_in, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, sum_in, carry_in, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/csa_resolver_digit_adder.sv
// Combinational DIGIT-bit ripple full-adder chain used by the resolver.
module digit_adder #(
    parameter int DIGIT = csa_pkg::CSA_DIGIT
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o
);
    logic [DIGIT:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[DIGIT];
endmodule

// File: rtl/csa_resolver.sv
// Digit-serial carry-propagate resolver: turns a (sum, carry) pair into a
// WIDTH+1-bit binary result, DIGIT bits per cycle.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int DIGIT = CSA_DIGIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csa_resolver_if.slave        bus,
    output csa_state_e           state_o
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = csa_cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    csa_state_e       state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]   result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;

    logic [DIGIT-1:0] dig;
    logic             dig_cout;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a_i    (s_q[DIGIT-1:0]),
        .b_i    (c_q[DIGIT-1:0]),
        .cin_i  (cy_q),
        .sum_o  (dig),
        .cout_o (dig_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= '0;
            c_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            c_q      <= c_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            cy_q     <= cy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        c_d      = c_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        cy_d     = cy_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    s_d     = bus.sum_in;
                    c_d     = bus.carry_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    cy_d    = 1'b0;
                end
            end
            RUN: begin
                // New digits enter at the top so the LSB digit ends at bit 0.
                s_d   = s_q >> DIGIT;
                c_d   = c_q >> DIGIT;
                acc_d = (acc_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
                cy_d  = dig_cout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    result_d = {dig_cout, acc_d};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.busy      = (state_q != IDLE);
    assign state_o       = state_q;
endmodule

// File: tb/tb_csa_resolver.sv
// Bench for csa_resolver: directed steps plus random operands against a plain
// addition model, on a DIGIT=1 and a DIGIT=5 instance.
module tb_csa_resolver;
    import csa_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cur;

    csa_resolver_if #(.WIDTH(5)) if_a ();
    csa_resolver_if #(.WIDTH(5)) if_b ();
    csa_state_e st_a, st_b;

    csa_resolver #(.WIDTH(5), .DIGIT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave), .state_o(st_a)
    );
    csa_resolver #(.WIDTH(5), .DIGIT(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave), .state_o(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       ov, ir, bz;
    logic [5:0] res;
    always_comb begin
        ov  = (cur == 0) ? if_a.out_valid : if_b.out_valid;
        ir  = (cur == 0) ? if_a.in_ready  : if_b.in_ready;
        bz  = (cur == 0) ? if_a.busy      : if_b.busy;
        res = (cur == 0) ? if_a.result    : if_b.result;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] s, input logic [4:0] c, input logic ordy);
        if (cur == 0) begin
            if_a.in_valid = v; if_a.sum_in = s; if_a.carry_in = c; if_a.out_ready = ordy;
        end else begin
            if_b.in_valid = v; if_b.sum_in = s; if_b.carry_in = c; if_b.out_ready = ordy;
        end
    endtask

    // One complete operation; starts and ends just after a falling edge.
    task automatic do_op(input logic [4:0] s, input logic [4:0] c, input int n_exp,
                         input int hold, input logic nxt_v,
                         input logic [4:0] ns, input logic [4:0] nc);
        logic [5:0] exp_r;
        int k;
        exp_r = 6'(s) + 6'(c);
        drive(1'b1, s, c, 1'b0);
        #1;
        chk("accept_ready", 32'(ir), 1);
        @(negedge clk);
        drive(nxt_v, ns, nc, 1'b0);
        k = 0;
        while (!ov && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, n_exp);
        chk("result", 32'(res), 32'(exp_r));
        chk("busy_done", 32'(bz), 1);
        chk("ready_done", 32'(ir), 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(ov), 1);
            chk("hold_result", 32'(res), 32'(exp_r));
            chk("hold_ready", 32'(ir), 0);
        end
        drive(nxt_v, ns, nc, 1'b1);
        @(negedge clk);
        drive(nxt_v, ns, nc, 1'b0);
        chk("release_valid", 32'(ov), 0);
        chk("release_ready", 32'(ir), 1);
    endtask

    initial begin
        int seen;
        logic [4:0] rs, rc;
        checks   = 0;
        failures = 0;
        cur      = 1;
        drive(1'b1, 5'd9, 5'd9, 1'b0);
        cur      = 0;
        drive(1'b1, 5'd9, 5'd9, 1'b0);
        rst_n    = 1'b0;

        // Reset with in_valid asserted
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(ov), 0);
        chk("rst_result", 32'(res), 0);
        chk("rst_busy", 32'(bz), 0);
        chk("rst_in_ready", 32'(ir), 0);
        chk("rst_b_in_ready", 32'(if_b.in_ready), 0);
        drive(1'b0, 5'd0, 5'd0, 1'b0);
        cur = 1;
        drive(1'b0, 5'd0, 5'd0, 1'b0);
        cur = 0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(ir), 1);
        @(negedge clk);
        chk("post_rst_idle", 32'(bz), 0);
        chk("post_rst_b_idle", 32'(if_b.busy), 0);

        // Directed operands
        do_op(5'd1, 5'd1, 5, 0, 1'b0, 5'd0, 5'd0);
        do_op(5'd31, 5'd31, 5, 0, 1'b0, 5'd0, 5'd0);
        do_op(5'd10, 5'd11, 5, 3, 1'b1, 5'd7, 5'd8);
        do_op(5'd7, 5'd8, 5, 0, 1'b0, 5'd0, 5'd0);

        // Reset during RUN discards the operation
        drive(1'b1, 5'd14, 5'd12, 1'b0);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_busy", 32'(bz), 0);
        chk("midrst_valid", 32'(ov), 0);
        chk("midrst_result", 32'(res), 0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov) seen++;
        end
        chk("midrst_no_output", seen, 0);
        do_op(5'd3, 5'd4, 5, 0, 1'b0, 5'd0, 5'd0);

        // Single-digit instance
        cur = 1;
        do_op(5'd17, 5'd14, 1, 0, 1'b0, 5'd0, 5'd0);
        do_op(5'd0, 5'd0, 1, 0, 1'b0, 5'd0, 5'd0);

        // Random operands on both instances
        for (int t = 0; t < 24; t++) begin
            cur = int'($urandom_range(0, 1));
            rs  = 5'($urandom_range(0, 31));
            rc  = 5'($urandom_range(0, 31));
            do_op(rs, rc, (cur == 0) ? 5 : 1, int'($urandom_range(0, 2)),
                  1'b0, 5'd0, 5'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csa_resolver.md
# csa_resolver

Carry-propagate resolution stage placed directly downstream of the carry-save adder. Accepts one redundant operand pair (sum vector, carry vector) over a valid/ready handshake. Resolves it digit-serially into a single binary result, WIDTH/DIGIT cycles per operation. Presents the WIDTH+1-bit result over a second valid/ready handshake, holding it until the consumer takes it.

## Interface
- WIDTH, 5: width of each redundant input vector; matches the carry-save adder's sum output.
- DIGIT, 1: bits resolved per cycle; WIDTH must be an integer multiple of DIGIT. N = WIDTH/DIGIT.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept; = (state==IDLE) && rst_n.
- sum_in  in  WIDTH  sum vector of the carry-save pair.
- carry_in  in  WIDTH  carry vector, already weight-aligned to sum_in by the upstream stage.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH+1  sum_in + carry_in, unsigned.
- busy  out  1  state != IDLE.

## Operation
- States:
  - IDLE → RUN on the in_valid && in_ready edge.
  - RUN → DONE when the digit count reaches N-1.
  - DONE → IDLE on the out_valid && out_ready edge.
- IDLE accept:
  - sum_in and carry_in are captured into shift registers s_q and c_q.
  - The carry flop cy is cleared and the digit counter cnt is set to 0.
- RUN, every cycle:
  - {cy, d} = s_q[DIGIT-1:0] + c_q[DIGIT-1:0] + cy.
  - s_q and c_q shift right by DIGIT; d shifts into the top of the result accumulator; cnt increments.
- RUN → DONE edge: result[WIDTH] is loaded with the final cy, and the accumulated digits fill result[WIDTH-1:0].
- DONE: out_valid = 1; result holds stable until the handshake completes.
- Arithmetic: unsigned; the output is WIDTH+1 bits, so overflow is impossible.
- Inputs are ignored whenever in_ready = 0. No operand is queued.
- out_ready is ignored outside DONE.
- Reset values: state IDLE, out_valid 0, result 0, busy 0, cnt 0, cy 0, s_q/c_q 0. in_ready is 0 while rst_n is low.

## Timing
- Accept edge = edge 0. RUN occupies edges 1..N.
- out_valid rises after edge N, i.e. N cycles after the accept edge. N=5 at the defaults.
- Minimum initiation interval is N+2 cycles: the accept cycle, N RUN cycles, and one DONE cycle with out_ready high.
- in_ready is high in the cycle after the output handshake edge; a back-to-back accept is allowed there.
- Back-pressure: out_ready low in DONE holds out_valid=1 and result unchanged for any number of cycles.
- Output handshake and new input offered in the same cycle: the input is not accepted in that cycle, because in_ready=0 in DONE.
- Reset mid-operation: rst_n low at any edge forces IDLE and the reset values. The operation in flight is discarded and never produces out_valid.
- result is registered. No combinational path runs from an input to out_valid or result. in_ready depends only on state and rst_n.

## Structure
- Shared package csa_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the default constants CSA_WIDTH=5 and CSA_DIGIT=1, used by both this block and the carry-save adder so widths stay aligned.
- Sub-module digit_adder(DIGIT) implements the combinational DIGIT-bit ripple full-adder chain: a, b, cin → sum, cout. It is instantiated once.
- Top level contains the FSM, shift registers, counter (width $clog2(N+1)), and result register.

## Test plan
1. Reset: rst_n low 2 cycles with in_valid=1 → out_valid=0, result=0, busy=0, in_ready=0. After release, in_ready=1 and nothing was accepted.
2. sum_in=5'b00001, carry_in=5'b00001 → result=6'b000010; out_valid rises exactly 5 cycles after the accept edge.
3. sum_in=31, carry_in=31 → result=62 (6'b111110), exercising the top carry into result[5].
4. sum_in=10, carry_in=11, with out_ready low for 3 cycles in DONE and a second pair (7,8) offered throughout:
   - result=21 held with out_valid=1 and in_ready=0;
   - after out_ready, (7,8) is accepted on the next cycle → result=15.
5. Pulse rst_n low 2 cycles into RUN on operand (14,12) → out_valid never asserts for it. Then operand (3,4) → result=7.
6. Re-elaborate with DIGIT=5 (N=1):
   - (17,14) → result=31 with out_valid 1 cycle after accept;
   - (0,0) → result=0.
